parity_mem_arbiter: RTL and testbench
=====================================

Name: parity_mem_arbiter

Overview:
- Two-requester arbiter and sequencer for a parity-protected 16-bit data store.
- On write, computes 8 check bits over the 16-bit word and stores a 24-bit codeword {check, data} in an external synchronous SRAM.
- On read, recomputes the check bits from the returned data, forms a syndrome and flags a mismatch to the requester.
- Sits between two bus masters (port 0 = core, port 1 = DMA/debug) and a single-port 24-bit RAM.

Parameters:
ADDR_W, 10, word address width of the external RAM
ERRCNT_W, 8, width of the saturating error counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  2  per-port request valid (bit i = port i)
req_ready  out  2  per-port request accept, one-hot or zero
req_we  in  2  per-port write enable (1 = write, 0 = read)
req_addr  in  2*ADDR_W  per-port address, port i at [i*ADDR_W +: ADDR_W]
req_wdata  in  32  per-port write data, port i at [i*16 +: 16]
rsp_valid  out  2  per-port response valid, one-hot or zero
rsp_ready  in  2  per-port response accept
rsp_rdata  out  16  read data (shared, qualified by rsp_valid)
rsp_err  out  1  parity mismatch on this read (0 for writes)
rsp_syndrome  out  8  recomputed check XOR stored check (0 for writes)
mem_en  out  1  RAM access strobe
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  24  {check[7:0], data[15:0]}
mem_rdata  in  24  RAM read data, valid 1 cycle after the mem_en read cycle
err_count  out  ERRCNT_W  saturating count of reads with rsp_err=1

Behaviour:
- Clock, reset: one clock domain (clk). Reset is asynchronous and active-low (rst_n).
- Check function chk(d), with c[k] = XOR of the listed data bits:
  - c0 = d[7:0]; c1 = d[15:8]
  - c2 = d0,d1,d8,d9; c3 = d2,d3,d10,d11; c4 = d4,d5,d12,d13; c5 = d6,d7,d14,d15
  - c6 = even bits d0,d2,...,d14; c7 = odd bits d1,d3,...,d15
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is set, grant one port and assert its req_ready combinationally in the same cycle.
  - Latch we, addr and wdata for the granted port, plus grant_id. Next state is ISSUE.
  - If no request is valid, stay in IDLE.
- Arbitration: round-robin on last_served.
  - If both ports are valid, grant the port that is not last_served.
  - If one port is valid, grant it.
  - last_served updates when the response handshake completes.
  - Reset value of last_served is 1, so port 0 wins the first contention.
- ISSUE:
  - mem_en=1, mem_we=latched we, mem_addr=latched addr, mem_wdata={chk(wdata), wdata}.
  - Write: next state RESP. Read: next state WAIT.
- WAIT:
  - Sample mem_rdata and register rdata=mem_rdata[15:0] and syndrome=chk(mem_rdata[15:0]) ^ mem_rdata[23:16].
  - err = |syndrome. Next state RESP.
  - If err, err_count increments by 1 in this cycle and saturates at all-ones.
- RESP:
  - rsp_valid[grant_id]=1; rsp_rdata, rsp_err and rsp_syndrome stay stable until rsp_ready[grant_id]=1.
  - For writes, rsp_rdata=0, rsp_err=0, rsp_syndrome=0.
  - On handshake, go to IDLE and set last_served=grant_id. No new grant is made in the same cycle.
  - rsp_ready on the non-granted port is ignored.
- Latency from accept cycle T: read response valid at T+3, write response valid at T+2.
- Throughput: at most one transaction is outstanding. req_ready is 0 outside IDLE.
- mem_en and mem_we are 0 in every state except ISSUE. mem_addr and mem_wdata are don't-care when mem_en=0 but are registered and hold their last value.
- Reset (asynchronous, any state, including mid-transaction):
  - State goes to IDLE; all outputs go to 0 (req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_syndrome, mem_en, mem_we, mem_addr, mem_wdata, err_count).
  - last_served goes to 1.
  - An in-flight transaction is dropped with no response. A RAM write already issued is not undone.
- Request signals on a port must be held stable while req_valid is high and unaccepted. The block does not check this.

Test Plan:
- Write port 0, addr 5, data 0x0001: mem_wdata=24'h450001 and mem_we=1 at T+1; rsp_valid[0] at T+2 with rsp_err=0. Read addr 5 with a RAM model: rsp_rdata=0x0001, rsp_err=0, rsp_syndrome=0x00 at T+3.
- Write data 0x8001 then 0xFFFF: stored check 0xE7, then 0x00. Both read back with rsp_err=0.
- Read with the RAM model returning 24'h450003 (d1 flipped): rsp_err=1, rsp_syndrome=0x85 (c0, c2, c7), err_count 0 -> 1. Force 300 such reads: err_count holds at 255.
- Both ports assert req_valid every cycle after reset: grants alternate 0,1,0,1, and each grant waits for the previous response handshake. Hold rsp_ready=0 for 4 cycles: rsp_valid and rsp_rdata stay stable, and no new req_ready is asserted.
- Deassert rst_n during WAIT of a read: all outputs are 0 immediately. After release, a port 1 request is accepted in the first IDLE cycle, and port 0 wins the next contention.

Source files
------------

// File: rtl/parity_mem_arbiter.sv
// Round-robin arbiter for two bus masters in front of a single-port 24-bit SRAM.
// Writes store {check, data}; reads recompute the check bits and report the syndrome.
module parity_mem_arbiter #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned ERRCNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_we,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [31:0]           req_wdata,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [15:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [7:0]            rsp_syndrome,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [23:0]           mem_wdata,
  input  logic [23:0]           mem_rdata,
  output logic [ERRCNT_W-1:0]   err_count
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CHK_W  = 8;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_e;

  function automatic logic [CHK_W-1:0] chk(input logic [DATA_W-1:0] d);
    logic [CHK_W-1:0] c;
    c[0] = ^d[7:0];
    c[1] = ^d[15:8];
    c[2] = ^{d[9:8],   d[1:0]};
    c[3] = ^{d[11:10], d[3:2]};
    c[4] = ^{d[13:12], d[5:4]};
    c[5] = ^{d[15:14], d[7:6]};
    c[6] = 1'b0;
    c[7] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      c[6] = c[6] ^ d[2*i];
      c[7] = c[7] ^ d[2*i+1];
    end
    return c;
  endfunction

  state_e                state_q, state_d;
  logic                  last_q, last_d;
  logic                  gid_q, gid_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [23:0]           mem_wdata_q, mem_wdata_d;
  logic [1:0]            rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [CHK_W-1:0]      rsp_syn_q, rsp_syn_d;
  logic [ERRCNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic                  gsel_c;
  logic [DATA_W-1:0]     sel_wdata_c;
  logic [ADDR_W-1:0]     sel_addr_c;
  logic [CHK_W-1:0]      rd_syn_c;

  // Contention goes to the port that was not served last
  assign gsel_c      = (req_valid == 2'b11) ? ~last_q : req_valid[1];
  assign sel_wdata_c = gsel_c ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
  assign sel_addr_c  = gsel_c ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
  assign rd_syn_c    = chk(mem_rdata[DATA_W-1:0]) ^ mem_rdata[23:16];

  // Accept is combinational; held low while reset is asserted
  assign req_ready = (rst_n && state_q == ST_IDLE && (|req_valid)) ?
                     (gsel_c ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;
      gid_q       <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_syn_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gid_q       <= gid_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_syn_q   <= rsp_syn_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gid_d       = gid_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_syn_d   = rsp_syn_q;
    err_cnt_d   = err_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          gid_d       = gsel_c;
          mem_en_d    = 1'b1;
          mem_we_d    = req_we[gsel_c];
          mem_addr_d  = sel_addr_c;
          mem_wdata_d = {chk(sel_wdata_c), sel_wdata_c};
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mem_we_q) begin
          rsp_valid_d = gid_q ? 2'b10 : 2'b01;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          rsp_syn_d   = '0;
          state_d     = ST_RESP;
        end else begin
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        rsp_valid_d = gid_q ? 2'b10 : 2'b01;
        rsp_rdata_d = mem_rdata[DATA_W-1:0];
        rsp_syn_d   = rd_syn_c;
        rsp_err_d   = |rd_syn_c;
        if ((|rd_syn_c) && (err_cnt_q != {ERRCNT_W{1'b1}})) begin
          err_cnt_d = err_cnt_q + ERRCNT_W'(1);
        end
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready[gid_q]) begin
          rsp_valid_d = '0;
          last_d      = gid_q;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_en       = mem_en_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_err      = rsp_err_q;
  assign rsp_syndrome = rsp_syn_q;
  assign err_count    = err_cnt_q;

endmodule

// File: tb/tb_parity_mem_arbiter.sv
// Directed bench for parity_mem_arbiter with a behavioural synchronous RAM.
module tb_parity_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, req_we;
  logic [19:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  rsp_valid, rsp_ready;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  rsp_syndrome;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [23:0] mem_wdata, mem_rdata;
  logic [7:0]  err_count;

  logic [23:0] ram [0:1023];
  logic [23:0] ram_q = '0;
  logic        force_en;
  logic [23:0] force_val;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  parity_mem_arbiter #(.ADDR_W(10), .ERRCNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_syndrome(rsp_syndrome),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .err_count(err_count)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        ram_q <= ram[mem_addr];
    end
  end
  assign mem_rdata = force_en ? force_val : ram_q;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_port(input int p, input bit we, input logic [9:0] addr, input logic [15:0] data);
    req_we[p] = we;
    req_addr[p*10 +: 10] = addr;
    req_wdata[p*16 +: 16] = data;
  endtask

  // Single transaction from IDLE, checking each cycle of the fixed latency
  task automatic txn(input int p, input bit we, input logic [9:0] addr, input logic [15:0] data,
                     input logic [15:0] exp_rd, input bit exp_err, input logic [7:0] exp_syn,
                     input logic [23:0] exp_wd);
    logic [1:0] oh;
    oh = (p == 1) ? 2'b10 : 2'b01;
    set_port(p, we, addr, data);
    req_valid = oh;
    #1 check_eq("req_ready", 32'(req_ready), 32'(oh));
    @(posedge clk); #1;
    req_valid = 2'b00;
    check_eq("issue_en", 32'(mem_en), 32'd1);
    check_eq("issue_we", 32'(mem_we), 32'(we));
    check_eq("issue_addr", 32'(mem_addr), 32'(addr));
    if (we) check_eq("issue_wdata", 32'(mem_wdata), 32'(exp_wd));
    @(posedge clk); #1;
    if (!we) begin
      check_eq("rsp_early", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
    end
    check_eq("rsp_valid", 32'(rsp_valid), 32'(oh));
    check_eq("mem_en_off", 32'(mem_en), 32'd0);
    check_eq("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
    check_eq("rsp_err", 32'(rsp_err), 32'(exp_err));
    check_eq("rsp_syn", 32'(rsp_syndrome), 32'(exp_syn));
    rsp_ready = oh;
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    check_eq("rsp_done", 32'(rsp_valid), 32'd0);
  endtask

  // Waits after the ISSUE cycle for a response; returns cycles taken, 0 on timeout
  task automatic wait_rsp(output int n);
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (rsp_valid != 2'b00) begin
        n = i;
        break;
      end
    end
    if (n == 0) check_eq("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
    check_eq({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    check_eq({tag, "_rsp_syn"}, 32'(rsp_syndrome), 32'd0);
    check_eq({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    check_eq({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check_eq({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check_eq({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check_eq({tag, "_err_count"}, 32'(err_count), 32'd0);
  endtask

  initial begin
    int n;
    logic [1:0]  exp_oh;
    logic [15:0] exp_d;
    rst_n = 1'b0;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    rsp_ready = '0; force_en = 1'b0; force_val = '0;
    #23;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    txn(0, 1'b1, 10'd5, 16'h0001, 16'h0000, 1'b0, 8'h00, 24'h450001);
    txn(0, 1'b0, 10'd5, 16'h0000, 16'h0001, 1'b0, 8'h00, 24'h0);
    txn(1, 1'b1, 10'd6, 16'h8001, 16'h0000, 1'b0, 8'h00, 24'hE78001);
    txn(1, 1'b0, 10'd6, 16'h0000, 16'h8001, 1'b0, 8'h00, 24'h0);
    txn(0, 1'b1, 10'd7, 16'hFFFF, 16'h0000, 1'b0, 8'h00, 24'h00FFFF);
    txn(0, 1'b0, 10'd7, 16'h0000, 16'hFFFF, 1'b0, 8'h00, 24'h0);
    check_eq("err_count_clean", 32'(err_count), 32'd0);

    force_en = 1'b1; force_val = 24'h450003;
    txn(0, 1'b0, 10'd5, 16'h0000, 16'h0003, 1'b1, 8'h85, 24'h0);
    check_eq("err_count_one", 32'(err_count), 32'd1);
    for (int k = 0; k < 299; k++) begin
      set_port(0, 1'b0, 10'd5, 16'h0000);
      req_valid = 2'b01;
      @(posedge clk); #1;
      req_valid = 2'b00;
      wait_rsp(n);
      if (n == 0) break;
      rsp_ready = 2'b01;
      @(posedge clk); #1;
      rsp_ready = 2'b00;
    end
    check_eq("err_count_sat", 32'(err_count), 32'd255);
    force_en = 1'b0;

    rst_n = 1'b0; #2 rst_n = 1'b1;
    check_eq("err_count_rst", 32'(err_count), 32'd0);
    @(posedge clk); #1;

    // Contention: both ports always valid, grants alternate starting at port 0
    set_port(0, 1'b0, 10'd5, 16'h0000);
    set_port(1, 1'b0, 10'd6, 16'h0000);
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_oh = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_d  = (i % 2 == 0) ? 16'h0001 : 16'h8001;
      #0 check_eq("rr_grant", 32'(req_ready), 32'(exp_oh));
      @(posedge clk); #1;
      check_eq("rr_busy", 32'(req_ready), 32'd0);
      wait_rsp(n);
      check_eq("rr_latency", 32'(n), 32'd2);
      check_eq("rr_valid", 32'(rsp_valid), 32'(exp_oh));
      check_eq("rr_rdata", 32'(rsp_rdata), 32'(exp_d));
      if (i == 0) begin
        rsp_ready = 2'b10;
        for (int h = 0; h < 4; h++) begin
          @(posedge clk); #1;
          check_eq("hold_valid", 32'(rsp_valid), 32'(exp_oh));
          check_eq("hold_rdata", 32'(rsp_rdata), 32'(exp_d));
          check_eq("hold_ready", 32'(req_ready), 32'd0);
        end
      end
      rsp_ready = 2'b11;
      @(posedge clk); #1;
      rsp_ready = 2'b00;
    end
    req_valid = 2'b00;
    @(posedge clk); #1;

    // Asynchronous reset while a read sits in WAIT
    set_port(0, 1'b0, 10'd5, 16'h0000);
    req_valid = 2'b01;
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    set_port(1, 1'b0, 10'd6, 16'h0000);
    req_valid = 2'b10;
    rst_n = 1'b0;
    #1 check_all_zero("midrst");
    #2 rst_n = 1'b1;
    #1 check_eq("post_rst_grant", 32'(req_ready), 32'd2);
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_rsp(n);
    check_eq("post_rst_valid", 32'(rsp_valid), 32'd2);
    check_eq("post_rst_rdata", 32'(rsp_rdata), 32'h8001);
    rsp_ready = 2'b10;
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    req_valid = 2'b11;
    #1 check_eq("post_rst_rr", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_rsp(n);
    rsp_ready = 2'b11;
    @(posedge clk); #1;
    rsp_ready = 2'b00;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
